// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen
// Front end for the SR flip-flop stage. Two raw asynchronous push-buttons
// (set, reset) are synchronized, debounced and edge-detected into clean
// single-cycle S/R command pulses. S and R are never asserted together;
// a same-cycle collision is resolved by RST_PRIORITY and the loser is dropped.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   set_btn       in   raw asynchronous set button, active-high
//   reset_btn     in   raw asynchronous reset button, active-high
//   S             out  registered one-cycle set command
//   R             out  registered one-cycle reset command
//   set_lvl       out  debounced set-button level
//   reset_lvl     out  debounced reset-button level
//   conflict      out  (SR_CMD_CONFLICT_EN only) pulse when a collision was arbitrated
//   conflict_seen out  (SR_CMD_CONFLICT_EN only) sticky collision flag, cleared by rst_n
//
// Build option: define SR_CMD_CONFLICT_EN to add the conflict outputs.
// S/R behaviour is identical with or without it.

module sr_cmd_gen #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEB_CYCLES   = 16,
  parameter int RST_PRIORITY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic reset_btn,
  output logic S,
  output logic R,
  output logic set_lvl,
  output logic reset_lvl
`ifdef SR_CMD_CONFLICT_EN
  ,
  output logic conflict,
  output logic conflict_seen
`endif
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  // channel 0 = set, channel 1 = reset
  logic [1:0] btn;
  logic [1:0] lvl;
  logic [1:0] req;

  assign btn = {reset_btn, set_btn};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_x;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   lvl_hist_q;

    assign sync_x = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn[ch]};
      end
    end

    // Any sample that agrees with the accepted level restarts the count,
    // so only an uninterrupted run of DEB_CYCLES differing samples flips lvl.
    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (sync_x != lvl_q) begin
        if (cnt_q == CNT_LAST) begin
          lvl_d = sync_x;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q      <= '0;
        lvl_q      <= 1'b0;
        lvl_hist_q <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        lvl_q      <= lvl_d;
        lvl_hist_q <= lvl_q;
      end
    end

    assign lvl[ch] = lvl_q;
    // rising edge of the debounced level only; releases produce nothing
    assign req[ch] = lvl_q & ~lvl_hist_q;
  end

  logic s_q, s_d;
  logic r_q, r_d;
  logic both_req;

  assign both_req = req[0] & req[1];

  always_comb begin
    s_d = req[0];
    r_d = req[1];
    if (both_req) begin
      if (RST_PRIORITY != 0) begin
        s_d = 1'b0;
      end else begin
        r_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= 1'b0;
      r_q <= 1'b0;
    end else begin
      s_q <= s_d;
      r_q <= r_d;
    end
  end

  assign S         = s_q;
  assign R         = r_q;
  assign set_lvl   = lvl[0];
  assign reset_lvl = lvl[1];

`ifdef SR_CMD_CONFLICT_EN
  logic conflict_q, conflict_d;
  logic seen_q, seen_d;

  // aligned with the S/R register so the pulse coincides with the issued command
  assign conflict_d = both_req;
  assign seen_d     = seen_q | both_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
      seen_q     <= seen_d;
    end
  end

  assign conflict      = conflict_q;
  assign conflict_seen = seen_q;
`endif

endmodule

// File: tb/tb_sr_cmd_gen.sv
module tb_sr_cmd_gen;

  logic clk;
  logic rst_n;
  logic set_btn;
  logic reset_btn;
  logic S1, R1, sl1, rl1;
  logic S0, R0, sl0, rl0;
`ifdef SR_CMD_CONFLICT_EN
  logic cf1, cs1, cf0, cs0;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  sr_cmd_gen #(.SYNC_STAGES(2), .DEB_CYCLES(16), .RST_PRIORITY(1)) dut_rp1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .set_btn       (set_btn),
    .reset_btn     (reset_btn),
    .S             (S1),
    .R             (R1),
    .set_lvl       (sl1),
    .reset_lvl     (rl1)
`ifdef SR_CMD_CONFLICT_EN
    ,
    .conflict      (cf1),
    .conflict_seen (cs1)
`endif
  );

  sr_cmd_gen #(.SYNC_STAGES(2), .DEB_CYCLES(16), .RST_PRIORITY(0)) dut_rp0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .set_btn       (set_btn),
    .reset_btn     (reset_btn),
    .S             (S0),
    .R             (R0),
    .set_lvl       (sl0),
    .reset_lvl     (rl0)
`ifdef SR_CMD_CONFLICT_EN
    ,
    .conflict      (cf0),
    .conflict_seen (cs0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // S and R together is never legal, in either build or priority
  always @(negedge clk) begin
    check_eq("inv_sr_rp1", int'(S1 & R1), 0);
    check_eq("inv_sr_rp0", int'(S0 & R0), 0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // returns 1ns after a rising edge with rst_n released, so the next edge is edge 1
  task automatic do_reset;
    rst_n     = 1'b0;
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int s_cnt, r_cnt, s0_cnt, lvl_seen;
`ifdef SR_CMD_CONFLICT_EN
  int cf1_cnt, cf0_cnt;
`endif

  initial begin
    rst_n     = 1'b1;
    set_btn   = 1'b1;
    reset_btn = 1'b0;

    // asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    set_btn   = 1'($urandom_range(1));
    reset_btn = 1'($urandom_range(1));
    #1;
    check_eq("rst0_S",   int'(S1),  0);
    check_eq("rst0_R",   int'(R1),  0);
    check_eq("rst0_sl",  int'(sl1), 0);
    check_eq("rst0_rl",  int'(rl1), 0);

    // clean press, held 40 cycles
    do_reset();
    set_btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      check_eq("clean_S",   int'(S1),  int'(k == 19));
      check_eq("clean_lvl", int'(sl1), int'(k >= 18));
      check_eq("clean_R",   int'(R1),  0);
      check_eq("clean_S0",  int'(S0),  int'(k == 19));
    end

    // release and catch the debouncer mid-count with an async reset
    set_btn = 1'b0;
    repeat (5) tick();
    check_eq("midcnt_lvl_before", int'(sl1), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_sl", int'(sl1), 0);
    check_eq("async_rst_S",  int'(S1),  0);
    check_eq("async_rst_R",  int'(R1),  0);

    // 15-cycle glitch must be rejected
    do_reset();
    set_btn  = 1'b1;
    s_cnt    = 0;
    lvl_seen = 0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 16) set_btn = 1'b0;
      tick();
      s_cnt += int'(S1);
      lvl_seen |= int'(sl1);
    end
    check_eq("glitch15_pulses", s_cnt, 0);
    check_eq("glitch15_lvl",    lvl_seen, 0);

    // 16 cycles is just long enough
    do_reset();
    set_btn  = 1'b1;
    s_cnt    = 0;
    lvl_seen = 0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 17) set_btn = 1'b0;
      tick();
      s_cnt += int'(S1);
      lvl_seen |= int'(sl1);
    end
    check_eq("glitch16_pulses", s_cnt, 1);
    check_eq("glitch16_lvl",    lvl_seen, 1);

    // simultaneous press: priority decides, loser dropped
    do_reset();
    set_btn   = 1'b1;
    reset_btn = 1'b1;
    s_cnt  = 0;
    r_cnt  = 0;
    s0_cnt = 0;
`ifdef SR_CMD_CONFLICT_EN
    cf1_cnt = 0;
    cf0_cnt = 0;
`endif
    for (int k = 1; k <= 40; k++) begin
      tick();
      check_eq("simul_rp1_S", int'(S1), 0);
      check_eq("simul_rp1_R", int'(R1), int'(k == 19));
      check_eq("simul_rp0_S", int'(S0), int'(k == 19));
      check_eq("simul_rp0_R", int'(R0), 0);
      s_cnt  += int'(S1);
      r_cnt  += int'(R1);
      s0_cnt += int'(S0);
`ifdef SR_CMD_CONFLICT_EN
      check_eq("simul_conflict_rp1", int'(cf1), int'(k == 19));
      cf1_cnt += int'(cf1);
      cf0_cnt += int'(cf0);
`endif
    end
    check_eq("simul_r_total",  r_cnt,  1);
    check_eq("simul_s0_total", s0_cnt, 1);
    check_eq("simul_sl1", int'(sl1), 1);
    check_eq("simul_rl1", int'(rl1), 1);
    check_eq("simul_sl0", int'(sl0), 1);
    check_eq("simul_rl0", int'(rl0), 1);
`ifdef SR_CMD_CONFLICT_EN
    check_eq("conflict_rp1_total", cf1_cnt, 1);
    check_eq("conflict_rp0_total", cf0_cnt, 1);
    check_eq("conflict_seen_rp1",  int'(cs1), 1);
    check_eq("conflict_seen_rp0",  int'(cs0), 1);
`endif

    // staggered: reset button first sampled 5 edges after set
    do_reset();
    set_btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 6) reset_btn = 1'b1;
      tick();
      check_eq("stag_rp1_S", int'(S1), int'(k == 19));
      check_eq("stag_rp1_R", int'(R1), int'(k == 24));
      check_eq("stag_rp0_S", int'(S0), int'(k == 19));
      check_eq("stag_rp0_R", int'(R0), int'(k == 24));
    end
`ifdef SR_CMD_CONFLICT_EN
    check_eq("stag_no_conflict", int'(cs1), 0);
`endif

    // bounce every 3 cycles, settle high, reset mid-settle
    do_reset();
    s_cnt    = 0;
    lvl_seen = 0;
    for (int k = 1; k <= 30; k++) begin
      set_btn = (((k - 1) / 3) % 2) == 0;
      tick();
      s_cnt += int'(S1);
      lvl_seen |= int'(sl1);
    end
    set_btn = 1'b1;
    repeat (8) begin
      tick();
      s_cnt += int'(S1);
      lvl_seen |= int'(sl1);
    end
    check_eq("bounce_pulses_pre", s_cnt, 0);
    check_eq("bounce_lvl_pre",    lvl_seen, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("bounce_rst_sl", int'(sl1), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    s_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      check_eq("bounce_post_S", int'(S1), int'(k == 19));
      s_cnt += int'(S1);
    end
    check_eq("bounce_post_total", s_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
- Upstream command stage for the SR flip-flop stage; drives its S and R inputs.
- Turns two raw asynchronous push-button inputs (set, reset) into clean, synchronized, debounced, single-cycle S/R command pulses.
- Guarantees S and R are never asserted together, so the downstream invalid {S,R}=11 case is unreachable.

Parameters:
- SYNC_STAGES, 2, synchronizer flop depth per button; legal range >= 2.
- DEB_CYCLES, 16, consecutive stable samples needed to accept a new level; legal range >= 2. Counter width is $clog2(DEB_CYCLES).
- RST_PRIORITY, 1, on a same-cycle request: 1 = reset wins, 0 = set wins.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- set_btn, input, 1, raw asynchronous set button, active-high.
- reset_btn, input, 1, raw asynchronous reset button, active-high.
- S, output, 1, registered one-cycle set command to the SR stage.
- R, output, 1, registered one-cycle reset command to the SR stage.
- set_lvl, output, 1, debounced set-button level.
- reset_lvl, output, 1, debounced reset-button level.

Behaviour:
- Reset: rst_n low asynchronously clears all synchronizer flops, debounce counters, debounced levels, edge-history flops, S, R, set_lvl and reset_lvl to 0. Reset release is clean: the first active edge follows deassertion.
- Synchronizer: per channel, a SYNC_STAGES-deep flop chain; the last stage is sync_x.
- Debounce, per channel, with counter cnt and accepted level lvl:
  - sync_x == lvl: cnt <= 0.
  - sync_x != lvl and cnt < DEB_CYCLES-1: cnt <= cnt+1.
  - sync_x != lvl and cnt == DEB_CYCLES-1: lvl <= sync_x, cnt <= 0.
  - Any agreeing sample restarts the count, so glitches shorter than DEB_CYCLES samples are ignored.
- Edge detect: a request is raised when lvl goes 0->1 (lvl high, lvl_d low). Falling edges generate nothing.
- Latency: a clean input transition first sampled at edge N gives lvl=1 after edge N+SYNC_STAGES+DEB_CYCLES-1, and S (or R) high after edge N+SYNC_STAGES+DEB_CYCLES, for exactly one cycle. With defaults, N=1 gives S high after edge 19.
- Arbitration when set and reset requests are raised in the same cycle:
  - RST_PRIORITY=1: R=1, S=0.
  - RST_PRIORITY=0: S=1, R=0.
  - The losing request is dropped, not deferred.
- Requests in different cycles pass through independently.
- Held button: exactly one pulse per press, regardless of hold length. A new pulse requires release (debounced) and a re-press.
- Reset mid-debounce: the partial count is lost and no pulse is emitted.
- Button held through reset release: lvl starts at 0, so one pulse is emitted after the full synchronizer plus debounce latency.
- Invariant: S and R are never 1 in the same cycle, under any input or parameter combination.

Optional Feature:
- Macro: SR_CMD_CONFLICT_EN.
- Defined: adds two outputs, both reset to 0.
  - conflict, 1-bit: one-cycle pulse in the cycle S or R is issued due to arbitration, i.e. both requests raised together.
  - conflict_seen, 1-bit: sticky; set on the first conflict and cleared only by rst_n.
- Undefined: neither port exists and no conflict logic is synthesized. S/R behaviour is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with random buttons, including asserting mid-count -> S=R=set_lvl=reset_lvl=0 immediately, without waiting for a clk edge.
- Clean press (defaults): set_btn 0->1 sampled first at edge 1, held 40 cycles -> S=1 only after edge 19, set_lvl=1 from edge 18, R stays 0, no further S while held.
- Glitch: set_btn high for 15 cycles then low (defaults) -> no S pulse, set_lvl stays 0. Repeat with 16 cycles high -> exactly one S pulse.
- Simultaneous: both buttons rise on the same edge, RST_PRIORITY=1 -> R=1, S=0 for one cycle. Rerun with RST_PRIORITY=0 -> S=1, R=0. With SR_CMD_CONFLICT_EN, conflict pulses once and conflict_seen stays 1.
- Staggered: reset_btn rises 5 cycles after set_btn -> S pulse, then R pulse 5 cycles later. Never S&R=1, checked by assertion on every cycle.
- Bounce and reset: set_btn toggles every 3 cycles for 30 cycles, then settles high; rst_n pulsed low mid-settle -> no pulse before reset, then exactly one S pulse DEB_CYCLES+SYNC_STAGES edges after release sampling.
